// File: rtl/ram_arb_pkg.sv
// Shared types and default constants for the CPU/host RAM arbiter.
package ram_arb_pkg;

   localparam int unsigned ARB_ADDR_W       = 10;
   localparam int unsigned ARB_DATA_W       = 16;
   localparam int unsigned DEF_MAX_BURST    = 8;
   localparam int unsigned DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      S_CPU   = 2'd0,
      S_HOST  = 2'd1,
      S_YIELD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single-port data/program RAM between the CPU (default
// priority) and an external host/debug loader. The host wins when the CPU is
// idle or after STARVE_LIMIT denied cycles, and keeps the RAM for at most
// MAX_BURST grants before a one-cycle CPU-owned yield.
// Optional feature macro: RAM_ARB_WPROT_EN (drops host writes at or below
// WPROT_TOP and pulses host_err the following cycle).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ARB_ADDR_W,
   parameter int unsigned DATA_W       = ARB_DATA_W,
   parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
`ifdef RAM_ARB_WPROT_EN
   parameter logic [ADDR_W-1:0] WPROT_TOP = ADDR_W'(10'h0FF),
`endif
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic              host_we,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
   localparam int unsigned WAIT_W  = $clog2(STARVE_LIMIT + 1);

   arb_state_t          state_q, state_d;
   logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                host_rvalid_q;
   logic [DATA_W-1:0]   host_rdata_q;

   logic                grant_host_c;
   logic                host_wr_ok_c;
   logic                host_rd_c;
   logic                burst_last_c;
   logic                starved_c;

   assign burst_last_c = (32'(burst_cnt_q) + 32'd1) == MAX_BURST;
   assign starved_c    = (wait_cnt_q == WAIT_W'(STARVE_LIMIT));

   // Host grant decision; reset forces the CPU path with no write.
   always_comb begin
      grant_host_c = 1'b0;
      if (rst_n && host_req && (state_q != S_YIELD)) begin
         grant_host_c = (state_q == S_HOST) || !cpu_req || starved_c;
      end
   end

   // Host write qualification (protected window drops the write).
   always_comb begin
`ifdef RAM_ARB_WPROT_EN
      host_wr_ok_c = host_we && (host_addr > WPROT_TOP);
`else
      host_wr_ok_c = host_we;
`endif
   end

   assign host_rd_c = grant_host_c && !host_we;
   assign host_gnt  = grant_host_c;
   assign cpu_stall = cpu_req && grant_host_c;

   // RAM port mux between the granted requester and the CPU.
   always_comb begin
      ram_addr  = cpu_addr;
      ram_din   = cpu_din;
      ram_write = 1'b0;
      if (grant_host_c) begin
         ram_addr  = host_addr;
         ram_din   = host_wdata;
         ram_write = host_wr_ok_c;
      end else if (rst_n) begin
         ram_write = cpu_req && cpu_write;
      end
   end

   // Next state and burst counter.
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         S_CPU: begin
            if (grant_host_c) begin
               burst_cnt_d = BURST_W'(1);
               state_d     = (MAX_BURST == 1) ? S_YIELD : S_HOST;
            end
         end
         S_HOST: begin
            if (!host_req) begin
               state_d     = S_CPU;
               burst_cnt_d = '0;
            end else if (grant_host_c) begin
               if (burst_last_c) begin
                  state_d     = S_YIELD;
                  burst_cnt_d = '0;
               end else begin
                  burst_cnt_d = burst_cnt_q + BURST_W'(1);
               end
            end
         end
         S_YIELD: begin
            state_d     = S_CPU;
            burst_cnt_d = '0;
         end
         default: begin
            state_d     = S_CPU;
            burst_cnt_d = '0;
         end
      endcase
   end

   // Starvation counter: counts denied host-request cycles, saturating.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (grant_host_c || !host_req) begin
         wait_cnt_d = '0;
      end else if (!starved_c) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_CPU;
         burst_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   // Registered host read return, one cycle after the granted read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         host_rvalid_q <= host_rd_c;
         if (host_rd_c) begin
            host_rdata_q <= ram_dout;
         end
      end
   end

   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;

`ifdef RAM_ARB_WPROT_EN
   logic host_err_q;

   // Error pulse for a granted host write that hit the protected window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         host_err_q <= 1'b0;
      end else begin
         host_err_q <= grant_host_c && host_we && !host_wr_ok_c;
      end
   end

   assign host_err = host_err_q;
`else
   assign host_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// traffic against a tenure/cooldown/starvation reference model and a
// reference memory image.
module tb_ram_arbiter;

   localparam int          MAXB     = 8;
   localparam int          STARVE   = 4;
   localparam logic [9:0]  PROT_TOP = 10'h0FF;
   localparam logic [9:0]  WIN      = 10'h0F8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic [9:0]  cpu_addr = '0;
   logic        cpu_write = 1'b0;
   logic [15:0] cpu_din = '0;
   logic        cpu_stall;
   logic        host_req = 1'b0;
   logic [9:0]  host_addr = '0;
   logic        host_we = 1'b0;
   logic [15:0] host_wdata = '0;
   logic        host_gnt;
   logic        host_rvalid;
   logic [15:0] host_rdata;
   logic        host_err;
   logic [9:0]  ram_addr;
   logic        ram_write;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;

   ram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
      .cpu_din(cpu_din), .cpu_stall(cpu_stall),
      .host_req(host_req), .host_addr(host_addr), .host_we(host_we),
      .host_wdata(host_wdata), .host_gnt(host_gnt),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
      .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // RAM instance: asynchronous read, synchronous write, cleared at start.
   logic [15:0] ram_mem [1024];
   logic        mem_clr = 1'b1;
   assign ram_dout = ram_mem[ram_addr];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
      end else if (ram_write) begin
         ram_mem[ram_addr] <= ram_din;
      end
   end

   // Reference model state.
   logic [15:0] ref_mem [1024];
   int          tenure;      // grants so far in the current host tenure
   int          denied;      // consecutive denied host-request cycles
   bit          cooldown;    // CPU-owned cycle after a full burst
   logic        exp_rvalid;
   logic [15:0] exp_rdata;
   logic        exp_err;
   logic        last_exp_gnt;
   logic        obs_gnt, obs_stall, obs_wr;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check combinational outputs, clock, advance model,
   // check registered outputs.
   task automatic cycle();
      logic        g, wr, prot;
      logic [9:0]  a;
      logic [15:0] d;
      #2;
      g = rst_n && host_req && !cooldown &&
          (tenure > 0 || !cpu_req || denied >= STARVE);
`ifdef RAM_ARB_WPROT_EN
      prot = host_we && (host_addr <= PROT_TOP);
`else
      prot = 1'b0;
`endif
      a  = g ? host_addr : cpu_addr;
      d  = g ? host_wdata : cpu_din;
      wr = rst_n && (g ? (host_we && !prot) : (cpu_req && cpu_write));
      obs_gnt   = host_gnt;
      obs_stall = cpu_stall;
      obs_wr    = ram_write;
      check_eq("host_gnt", 32'(host_gnt), 32'(g));
      check_eq("cpu_stall", 32'(cpu_stall), 32'(cpu_req && g));
      check_eq("ram_write", 32'(ram_write), 32'(wr));
      if (rst_n) check_eq("ram_addr", 32'(ram_addr), 32'(a));
      if (wr) check_eq("ram_din", 32'(ram_din), 32'(d));
      last_exp_gnt = g;
      @(posedge clk);
      if (!rst_n) begin
         tenure = 0; denied = 0; cooldown = 1'b0;
         exp_rvalid = 1'b0; exp_rdata = '0; exp_err = 1'b0;
      end else begin
         exp_rvalid = g && !host_we;
         if (exp_rvalid) exp_rdata = ref_mem[host_addr];
         exp_err = g && prot;
         if (wr) ref_mem[a] = d;
         if (g) begin
            tenure++;
            denied = 0;
            cooldown = (tenure == MAXB);
            if (tenure == MAXB) tenure = 0;
         end else begin
            tenure = 0;
            cooldown = 1'b0;
            if (host_req) denied = (denied < STARVE) ? denied + 1 : STARVE;
            else denied = 0;
         end
      end
      #1;
      check_eq("host_rvalid", 32'(host_rvalid), 32'(exp_rvalid));
      check_eq("host_rdata", 32'(host_rdata), 32'(exp_rdata));
      check_eq("host_err", 32'(host_err), 32'(exp_err));
   endtask

   task automatic reset_dut();
      cpu_req = 1'b0; cpu_write = 1'b0; host_req = 1'b0; host_we = 1'b0;
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   int k;

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      tenure = 0; denied = 0; cooldown = 1'b0;
      exp_rvalid = 1'b0; exp_rdata = '0; exp_err = 1'b0; last_exp_gnt = 1'b0;

      // Reset state.
      cycle();
      mem_clr = 1'b0;
      cycle();
      check_eq("rst_rvalid", 32'(host_rvalid), 32'd0);
      check_eq("rst_rdata", 32'(host_rdata), 32'd0);
      rst_n = 1'b1;

      // Host only: three writes then a readback.
      host_req = 1'b1; host_we = 1'b1; host_wdata = 16'hA5A5;
      for (int i = 0; i < 3; i++) begin
         host_addr = 10'h300 + 10'(i);
         cycle();
         check_eq("ho_gnt", 32'(obs_gnt), 32'd1);
      end
      host_we = 1'b0; host_addr = 10'h301;
      cycle();
      check_eq("ho_rvalid", 32'(host_rvalid), 32'd1);
      check_eq("ho_rdata", 32'(host_rdata), 32'hA5A5);

      // Starvation and burst limit with a constantly requesting CPU.
      reset_dut();
      cpu_req = 1'b1; cpu_addr = WIN;
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'h301;
      for (int i = 0; i < 24; i++) begin
         cycle();
         check_eq("stv_gnt", 32'(obs_gnt), 32'((i % 12) >= 4));
         check_eq("stv_stall", 32'(obs_stall), 32'((i % 12) >= 4));
      end

      // Idle CPU: 8 grants, 1 yield cycle, repeating.
      reset_dut();
      host_req = 1'b1; host_we = 1'b1;
      k = 0;
      for (int i = 0; i < 27; i++) begin
         host_addr = 10'h320 + 10'(k);
         host_wdata = 16'(i + 16'h1000);
         cycle();
         check_eq("idle_gnt", 32'(obs_gnt), 32'((i % 9) != 8));
         check_eq("idle_wr", 32'(obs_wr), 32'((i % 9) != 8));
         if (last_exp_gnt) k++;
      end

      // Reset during the third host write.
      reset_dut();
      host_req = 1'b1; host_we = 1'b1; host_wdata = 16'h5A5A;
      for (int i = 0; i < 3; i++) begin
         host_addr = 10'h340 + 10'(i);
         rst_n = (i != 2);
         cycle();
      end
      check_eq("rmb_wr", 32'(obs_wr), 32'd0);
      check_eq("rmb_rvalid", 32'(host_rvalid), 32'd0);
      rst_n = 1'b1; host_req = 1'b0;
      cycle();
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'h342;
      cycle();
      check_eq("rmb_rd", 32'(host_rdata), 32'd0);
      host_req = 1'b0;
      cycle();

`ifdef RAM_ARB_WPROT_EN
      // Protected window: dropped write, error pulse, unchanged readback.
      host_req = 1'b1; host_we = 1'b1; host_addr = 10'h010; host_wdata = 16'h1234;
      cycle();
      check_eq("wp_gnt", 32'(obs_gnt), 32'd1);
      check_eq("wp_wr", 32'(obs_wr), 32'd0);
      check_eq("wp_err", 32'(host_err), 32'd1);
      host_we = 1'b0;
      cycle();
      check_eq("wp_rd", 32'(host_rdata), 32'd0);
      host_we = 1'b1; host_addr = 10'h100; host_wdata = 16'h4321;
      cycle();
      check_eq("wp_ok_err", 32'(host_err), 32'd0);
      host_we = 1'b0;
      cycle();
      check_eq("wp_ok_rd", 32'(host_rdata), 32'h4321);
      host_req = 1'b0;
      cycle();
`endif

      // Randomized traffic in a window straddling the protection boundary.
      for (int n = 0; n < 3000; n++) begin
         cpu_req   = ($urandom_range(0, 3) != 0);
         cpu_write = 1'($urandom_range(0, 1));
         cpu_addr  = WIN + 10'($urandom_range(0, 15));
         cpu_din   = 16'($urandom);
         if (host_req && !last_exp_gnt) begin
            if ($urandom_range(0, 9) == 0) host_req = 1'b0;
         end else begin
            host_req   = ($urandom_range(0, 2) != 0);
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = WIN + 10'($urandom_range(0, 15));
            host_wdata = 16'($urandom);
         end
         rst_n = ($urandom_range(0, 199) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
